// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared constants for the timer counter/compare block.
//   DEF_CNT_W / DEF_DATA_W / DEF_NUM_CH : default parameter values of
//                                         timer_cnt_cmp
//   ovf_bit()                           : index of the overflow flag in the
//                                         status / int_en / sts_clr vectors
//                                         (channels occupy the bits below it)
// ----------------------------------------------------------------------------
package timer_pkg;

    localparam int DEF_CNT_W  = 64;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NUM_CH = 2;

    // Overflow status sits directly above the channel flags.
    function automatic int ovf_bit(input int num_ch);
        return num_ch;
    endfunction

endpackage

// File: rtl/timer_cmp_ch.sv
// ----------------------------------------------------------------------------
// timer_cmp_ch
// One compare channel: word-writable compare register, hit detect against the
// current counter value, and a sticky status flag.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   wdata        : register write data (one word)
//   wr_sel       : per-word write select for this channel's compare register
//   tick_ok      : tick qualified by "no counter write this cycle"
//   count        : current (pre-edge) counter value
//   sts_clr      : write-1-to-clear strobe for this channel's flag
//   hit          : combinational hit for this cycle
//   sts          : sticky status flag
// ----------------------------------------------------------------------------
module timer_cmp_ch
    import timer_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NW     = CNT_W / DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NW-1:0]     wr_sel,
    input  logic              tick_ok,
    input  logic [CNT_W-1:0]  count,
    input  logic              sts_clr,
    output logic              hit,
    output logic              sts
);

    logic [CNT_W-1:0] cmp_q;
    logic             sts_q;

    // Compare uses the register value before any write in this cycle lands.
    assign hit = tick_ok & (count == cmp_q);
    assign sts = sts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q <= '1;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wr_sel[k]) begin
                    cmp_q[k*DATA_W +: DATA_W] <= wdata;
                end
            end
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sts_q <= 1'b0;
        end else if (hit) begin
            sts_q <= 1'b1;
        end else if (sts_clr) begin
            sts_q <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_cnt_cmp.sv
// ----------------------------------------------------------------------------
// timer_cnt_cmp
// Free-running up-counter, word-writable from a narrow register bus, with
// NUM_CH compare channels, an overflow flag, sticky status and a registered
// interrupt.
// Build option: define TIMER_CNT_AUTOCLR_EN to reload the counter with 0 on a
// channel-0 hit (periodic mode, period cmp[0]+1 ticks). Without it the
// counter free-runs and wraps only at all-ones.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   wdata       : register write data
//   cnt_wr_sel  : per-word counter write select
//   cmp_wr_sel  : per-channel, per-word compare write select (ch*NW+k)
//   count_en    : tick pulse from divisor
//   halt        : debug halt, blocks ticks while high
//   int_en      : interrupt enables, channels then overflow
//   sts_clr     : write-1-to-clear status strobes, same map as int_en
//   count       : current counter value
//   sts         : sticky status flags
//   irq         : registered OR of (sts & int_en)
// ----------------------------------------------------------------------------
module timer_cnt_cmp
    import timer_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [CNT_W/DATA_W-1:0] cnt_wr_sel,
    input  logic [NUM_CH*(CNT_W/DATA_W)-1:0] cmp_wr_sel,
    input  logic                 count_en,
    input  logic                 halt,
    input  logic [NUM_CH:0]      int_en,
    input  logic [NUM_CH:0]      sts_clr,
    output logic [CNT_W-1:0]     count,
    output logic [NUM_CH:0]      sts,
    output logic                 irq
);

    localparam int NW  = CNT_W / DATA_W;
    localparam int OVF = ovf_bit(NUM_CH);

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  next_val;
    logic [CNT_W-1:0]  inc_val;
    logic              tick;
    logic              tick_ok;
    logic              ovf_hit;
    logic              sts_ovf_q;
    logic              irq_q;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] ch_sts;

    assign tick     = count_en & ~halt;
    // A counter write in the same cycle suppresses hit/overflow detection.
    assign tick_ok  = tick & ~|cnt_wr_sel;
    assign next_val = count_q + CNT_W'(1);
    assign ovf_hit  = tick_ok & (count_q == {CNT_W{1'b1}});

`ifdef TIMER_CNT_AUTOCLR_EN
    assign inc_val = ch_hit[0] ? '0 : next_val;
`else
    assign inc_val = next_val;
`endif

    // Each word independently takes a write or the incremented value, so a
    // write to one word does not stall the carry into the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (cnt_wr_sel[k]) begin
                    count_q[k*DATA_W +: DATA_W] <= wdata;
                end else if (tick) begin
                    count_q[k*DATA_W +: DATA_W] <= inc_val[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        timer_cmp_ch #(
            .CNT_W  (CNT_W),
            .DATA_W (DATA_W),
            .NW     (NW)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wdata   (wdata),
            .wr_sel  (cmp_wr_sel[ch*NW +: NW]),
            .tick_ok (tick_ok),
            .count   (count_q),
            .sts_clr (sts_clr[ch]),
            .hit     (ch_hit[ch]),
            .sts     (ch_sts[ch])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sts_ovf_q <= 1'b0;
        end else if (ovf_hit) begin
            sts_ovf_q <= 1'b1;
        end else if (sts_clr[OVF]) begin
            sts_ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(sts & int_en);
        end
    end

    assign count = count_q;
    assign sts   = {sts_ovf_q, ch_sts};
    assign irq   = irq_q;

endmodule

// File: tb/tb_timer_cnt_cmp.sv
// ----------------------------------------------------------------------------
// tb_timer_cnt_cmp
// Directed bench for timer_cnt_cmp with default parameters (64-bit counter,
// 32-bit bus, two channels). Expected counter values are queued when a step is
// driven and popped once the edge has been taken.
// ----------------------------------------------------------------------------
module tb_timer_cnt_cmp;

    localparam int CNT_W  = 64;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 2;
    localparam int NW     = CNT_W / DATA_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [DATA_W-1:0]        wdata;
    logic [NW-1:0]            cnt_wr_sel;
    logic [NUM_CH*NW-1:0]     cmp_wr_sel;
    logic                     count_en;
    logic                     halt;
    logic [NUM_CH:0]          int_en;
    logic [NUM_CH:0]          sts_clr;
    logic [CNT_W-1:0]         count;
    logic [NUM_CH:0]          sts;
    logic                     irq;

    logic [CNT_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    timer_cnt_cmp #(
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wdata      (wdata),
        .cnt_wr_sel (cnt_wr_sel),
        .cmp_wr_sel (cmp_wr_sel),
        .count_en   (count_en),
        .halt       (halt),
        .int_en     (int_en),
        .sts_clr    (sts_clr),
        .count      (count),
        .sts        (sts),
        .irq        (irq)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Take one edge with whatever inputs are driven, then compare count
    // against the value queued for that edge.
    task automatic step_exp(input string tag, input logic [CNT_W-1:0] exp_cnt);
        exp_q.push_back(exp_cnt);
        step();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            chk(tag, count, exp_q.pop_front());
        end
    endtask

    task automatic tick_exp(input string tag, input logic [CNT_W-1:0] exp_cnt);
        count_en = 1'b1;
        step_exp(tag, exp_cnt);
        count_en = 1'b0;
    endtask

    task automatic cnt_write(input logic [NW-1:0] sel, input logic [DATA_W-1:0] d);
        cnt_wr_sel = sel;
        wdata      = d;
    endtask

    task automatic cmp_write(input int ch, input logic [CNT_W-1:0] val);
        for (int k = 0; k < NW; k++) begin
            cmp_wr_sel = '0;
            cmp_wr_sel[ch*NW + k] = 1'b1;
            wdata = val[k*DATA_W +: DATA_W];
            step();
        end
        cmp_wr_sel = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        wdata      = '0;
        cnt_wr_sel = '0;
        cmp_wr_sel = '0;
        count_en   = 1'b0;
        halt       = 1'b0;
        int_en     = '0;
        sts_clr    = '0;

        // Reset state, with a tick held high to show reset overrides it.
        count_en = 1'b1;
        do_reset();
        count_en = 1'b0;
        chk("rst_count", count, 64'h0);
        chk("rst_sts", {61'h0, sts}, 64'h0);
        chk("rst_irq", {63'h0, irq}, 64'h0);

        // Basic counting: 5 ticks.
        for (int i = 1; i <= 5; i++) begin
            tick_exp("cnt_basic", CNT_W'(i));
        end
        chk("basic_sts", {61'h0, sts}, 64'h0);
        chk("basic_irq", {63'h0, irq}, 64'h0);

        // Low-word write with tick: high word still takes the increment.
        cnt_write(2'b01, 32'hFFFF_FFFF);
        tick_exp("carry_wr", 64'h0000_0000_FFFF_FFFF);
        cnt_write(2'b00, 32'h0);
        tick_exp("carry_tick", 64'h0000_0001_0000_0000);
        chk("carry_sts", {61'h0, sts}, 64'h0);

        // Mid-count reset, then resume from 0.
        do_reset();
        chk("rst2_count", count, 64'h0);
        tick_exp("resume", 64'h1);

        // Compare channel 1 and interrupt.
        cmp_write(1, 64'd3);
        int_en = 3'b010;
        tick_exp("cmp_cnt2", 64'd2);
        tick_exp("cmp_cnt3", 64'd3);
        chk("pre_hit_sts", {61'h0, sts}, 64'h0);
        tick_exp("cmp_hit", 64'd4);
        chk("hit_sts", {61'h0, sts}, 64'h2);
        chk("hit_irq_lag", {63'h0, irq}, 64'h0);
        step();
        chk("hit_irq", {63'h0, irq}, 64'h1);
        sts_clr = 3'b010;
        step();
        sts_clr = 3'b000;
        chk("clr_sts", {61'h0, sts}, 64'h0);
        chk("clr_irq_lag", {63'h0, irq}, 64'h1);
        step();
        chk("clr_irq", {63'h0, irq}, 64'h0);

        // Compare write in the same cycle as a matching count uses old value.
        cmp_wr_sel = 4'b0010;
        wdata      = 32'h0;
        step();
        cmp_wr_sel = 4'b0001;
        wdata      = 32'd4;
        tick_exp("oldcmp_cnt", 64'd5);
        cmp_wr_sel = '0;
        chk("oldcmp_sts", {61'h0, sts}, 64'h0);

        // Overflow, with a same-cycle clear that must lose.
        cnt_write(2'b11, 32'hFFFF_FFFF);
        step_exp("ovf_load", 64'hFFFF_FFFF_FFFF_FFFF);
        cnt_write(2'b00, 32'h0);
        sts_clr = 3'b100;
        tick_exp("ovf_wrap", 64'h0);
        sts_clr = 3'b000;
        chk("ovf_sts", {61'h0, sts}, 64'h4);
        sts_clr = 3'b100;
        step();
        sts_clr = 3'b000;
        chk("ovf_clr", {61'h0, sts}, 64'h0);

        // Halt: ticks ignored, writes still effective, no hit while halted.
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_exp("halt_hold", 64'h0);
        end
        chk("halt_sts", {61'h0, sts}, 64'h0);
        cnt_write(2'b01, 32'd3);
        step_exp("halt_wr", 64'd3);
        cnt_write(2'b00, 32'h0);
        tick_exp("halt_nohit", 64'd3);
        chk("halt_nohit_sts", {61'h0, sts}, 64'h0);
        halt = 1'b0;
        tick_exp("unhalt_hit", 64'd4);
        chk("unhalt_sts", {61'h0, sts}, 64'h2);

        // Channel 0 at 4: periodic reload or free-run depending on build.
        do_reset();
        cmp_write(0, 64'd4);
        for (int i = 1; i <= 12; i++) begin
`ifdef TIMER_CNT_AUTOCLR_EN
            tick_exp("auto_seq", CNT_W'(i % 5));
`else
            tick_exp("free_seq", CNT_W'(i));
`endif
            if (i == 4) chk("ch0_pre", {63'h0, sts[0]}, 64'h0);
            if (i == 5) chk("ch0_set", {63'h0, sts[0]}, 64'h1);
        end
`ifdef TIMER_CNT_AUTOCLR_EN
        chk("auto_final", count, 64'd2);
`else
        chk("free_final", count, 64'd12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_cnt_cmp.md
TIMER_CNT_CMP -- requirements
Module: timer_cnt_cmp

Interface
REQ-001 SHALL have parameter CNT_W, default 64, meaning counter width in bits (multiple of DATA_W, 32..128).
REQ-002 SHALL have parameter DATA_W, default 32, meaning register write-bus width.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning number of compare channels (1..4).
REQ-004 SHALL define localparam NW = CNT_W/DATA_W, meaning the number of words per counter or compare register.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wdata  input  DATA_W  write data from regset.
REQ-008 SHALL have port cnt_wr_sel  input  NW  one-hot per-word counter write select; bit k selects counter word k.
REQ-009 SHALL have port cmp_wr_sel  input  NUM_CH*NW  per-channel, per-word compare write select; bit ch*NW+k selects word k of channel ch.
REQ-010 SHALL have port count_en  input  1  tick pulse from divisor.
REQ-011 SHALL have port halt  input  1  debug halt; level-sensitive; blocks counting.
REQ-012 SHALL have port int_en  input  NUM_CH+1  interrupt enables; bits [NUM_CH-1:0] are channels, bit NUM_CH is overflow.
REQ-013 SHALL have port sts_clr  input  NUM_CH+1  write-1-to-clear strobes for status, same bit map as int_en.
REQ-014 SHALL have port count  output  CNT_W  current counter value.
REQ-015 SHALL have port sts  output  NUM_CH+1  sticky status flags.
REQ-016 SHALL have port irq  output  1  registered OR of (sts & int_en).

Function
REQ-017 SHALL define tick = count_en & ~halt.
REQ-018 SHALL, per counter word k, update on the next edge with priority: cnt_wr_sel[k] -> wdata; else tick -> word k of next_val; else hold.
REQ-019 SHALL compute next_val = count + 1 modulo 2^CNT_W, carrying across all words, so a write to one word SHALL NOT block the increment of the other words in the same cycle.
REQ-020 SHALL write compare word k of channel ch with wdata when its select bit is set; otherwise hold.
REQ-021 SHALL define hit[ch] = tick & (count == cmp[ch]) & ~|cnt_wr_sel, evaluated on the pre-edge count and cmp.
REQ-022 SHALL define ovf_hit = tick & (count == all-ones) & ~|cnt_wr_sel, with count wrapping to 0.
REQ-023 SHALL set sts[ch] on the edge at which hit[ch] is true, and sts[NUM_CH] on the edge at which ovf_hit is true.
REQ-024 SHALL keep sts bits sticky until cleared by the corresponding sts_clr bit; set SHALL win over a clear in the same cycle.
REQ-025 SHALL produce irq one cycle after sts/int_en change (registered); irq SHALL deassert one cycle after the last enabled flag clears.
REQ-026 SHALL evaluate compare against the old cmp value when cmp is written in the same cycle; the new value takes effect from the next cycle.
REQ-027 SHALL ignore count_en pulses while halt is high (no count, no hit, no ovf); counter and compare writes remain effective during halt.

Reset
REQ-028 SHALL, on reset high at a clock edge, set count=0, all cmp=all-ones, sts=0, irq=0, overriding any write, tick or clear in that cycle.
REQ-029 SHALL accept reset mid-count and SHALL resume counting from 0 on the first tick after reset deasserts.

Configuration
REQ-030 SHALL, when macro TIMER_CNT_AUTOCLR_EN is defined, load count with 0 instead of next_val on a hit[0] cycle (periodic mode, period cmp[0]+1 ticks); sts[0] still sets, and ovf_hit cannot coincide unless cmp[0] = all-ones.
REQ-031 SHALL, without TIMER_CNT_AUTOCLR_EN, free-run through compare values, with wrap only at all-ones.

Structure
REQ-032 SHALL place the default CNT_W, DATA_W and NUM_CH constants and the status bit-index constants (OVF_BIT function of NUM_CH) in the shared package timer_pkg.
REQ-033 SHALL implement each compare channel (compare register, hit detect, sticky flag) as sub-module timer_cmp_ch, instantiated NUM_CH times via generate.

Verification
REQ-034 SHALL verify basic counting: defaults, reset, then 5 tick pulses -> count=5, sts=0, irq=0.
REQ-035 SHALL verify word write with carry: cnt_wr_sel=2'b01, wdata=32'hFFFF_FFFF plus tick, then tick -> count=64'h1_0000_0000 after the second tick.
REQ-036 SHALL verify compare and interrupt: cmp[1]=3, int_en[1]=1, ticks until count=3, then one tick -> sts[1]=1 on that edge, irq=1 one cycle later; sts_clr[1] -> sts[1]=0, then irq=0 one cycle later.
REQ-037 SHALL verify overflow: count=all-ones, tick -> count=0, sts[2]=1 (NUM_CH=2); simultaneous sts_clr[2] -> sts[2] still 1.
REQ-038 SHALL verify halt: halt=1, 10 tick pulses -> count unchanged, no status set; counter write during halt -> takes effect.
REQ-039 SHALL verify autoclear with TIMER_CNT_AUTOCLR_EN: cmp[0]=4, 12 ticks -> count sequence 0,1,2,3,4,0,1,..., sts[0] set at tick 5, final count=2.
